adc_spi_master: RTL and testbench
=================================

# adc_spi_master

Upstream companion of the ADC serial receiver. Derives a free-running serial clock `SCLK` from the system clock and frames each conversion with an active-low `CS`, so that the receiver, which samples `CS`/`SDATA` on `SCLK` falling edges, detects `CS` low, shifts 16 bits, then sees `CS` high and raises its done tick. Sits between the system clock domain and the external ADC pins; the receiver consumes its `SCLK` and `CS` outputs directly.

## Interface
- `DIV`, 5: clk cycles per SCLK half-period; legal ≥1; SCLK period = 2·DIV clk.
- `CS_LOW_SCLK`, 17: SCLK falling edges with CS low per frame; legal ≥17 (1 detect + 16 shift).
- `CS_HIGH_SCLK`, 3: SCLK falling edges with CS high between frames; legal ≥2.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request one frame; honoured only in IDLE.
- `SCLK`  out  1  serial clock to ADC and receiver, registered, 50 % duty.
- `CS`  out  1  active-low chip select, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_tick`  out  1  one-clk pulse on the clk edge where CS returns high.

## Operation
- Divider: counter `dcnt` 0..DIV-1. On the clk edge where `dcnt==DIV-1`, `dcnt`←0 and SCLK toggles; otherwise `dcnt`++. SCLK never stops, including in IDLE.
- Internal strobes (combinational, from registered state): `rise` = toggle edge with SCLK==0; `fall` = toggle edge with SCLK==1.
- CS changes only on `rise` edges, so CS is stable for half an SCLK period around every falling edge.
- States:
  - IDLE: CS=1. `start`=1 → ARM.
  - ARM: CS=1. On `rise`: CS←0, `ecnt`←0, → LOW.
  - LOW: each `fall` increments `ecnt`. On `rise` with `ecnt==CS_LOW_SCLK`: CS←1, `ecnt`←0, `frame_tick`←1, → HIGH.
  - HIGH: each `fall` increments `ecnt`. On `rise` with `ecnt==CS_HIGH_SCLK`: → IDLE (see Configuration for the continuous variant).
- `start` outside IDLE is ignored; no request is queued.
- `ecnt` width = clog2(max(CS_LOW_SCLK, CS_HIGH_SCLK)+1); no wrap is possible within legal parameter values.
- `busy` = (state≠IDLE), registered alongside state.

## Timing
- Reset values: SCLK=1, CS=1, busy=0, frame_tick=0, `dcnt`=0, `ecnt`=0, state IDLE.
- After reset release, first SCLK falling edge occurs DIV clk cycles later, and rising edges every 2·DIV clk thereafter.
- `start` high in cycle t (IDLE) → busy=1 from t+1; CS falls on the first `rise` edge after t (latency 1 to 2·DIV clk).
- If the `start` cycle is itself a `rise` edge, CS does not fall until the following `rise` edge.
- CS low duration = exactly CS_LOW_SCLK·2·DIV clk; CS high gap ≥ CS_HIGH_SCLK·2·DIV clk.
- `frame_tick` is registered high for exactly one clk, coinciding with the edge where CS goes 0→1.
- Reset mid-frame: on the next clk edge, all outputs return to reset values, so CS=1 and SCLK=1; reset has priority over every transition.

## Configuration
- `ADC_CONTINUOUS_EN` defined: `start` is ignored. Reset release enters ARM instead of IDLE, and HIGH's exit goes to LOW with CS←0 on the terminating `rise` edge. Frames repeat every (CS_LOW_SCLK+CS_HIGH_SCLK)·2·DIV clk, and busy stays 1 after reset release.
- `ADC_CONTINUOUS_EN` undefined: single-shot operation as specified under Operation.

## Test plan
- Reset with DIV=2: SCLK=1, CS=1, busy=0, frame_tick=0 during reset. First SCLK fall occurs 2 clk after release, and SCLK period is 4 clk.
- Single `start` with DIV=2 and defaults: CS low for 68 clk with 17 SCLK falls inside the window. One `frame_tick` pulse coincides with CS rising, and busy returns to 0 after 12 more clk of CS high.
- Chain with ADC receiver and an SDATA model that shifts 0xA5C3 MSB-first: receiver `data_Out`=0x5C3 and `rx_done_tick` pulses exactly once per frame.
- `start` pulses during LOW and HIGH: exactly one frame is produced and no second CS assertion occurs.
- `reset` asserted at the 8th falling edge of a frame: CS=1 and SCLK=1 one clk later. A new `start` afterwards produces a full 17-edge frame.
- `ADC_CONTINUOUS_EN` with DIV=2: back-to-back frames repeat with an 80 clk period and `frame_tick` every 80 clk. Driving `start` has no effect.

Source files
------------

// File: rtl/adc_spi_master.sv
// SPI-style master that frames ADC conversions: free-running SCLK plus active-low CS.
// Define ADC_CONTINUOUS_EN for back-to-back frames that start on their own after reset; undefined gives single-shot.
module adc_spi_master #(
  parameter int DIV          = 5,
  parameter int CS_LOW_SCLK  = 17,
  parameter int CS_HIGH_SCLK = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic SCLK,
  output logic CS,
  output logic busy,
  output logic frame_tick
);

  localparam int DCNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ECNT_MAX = (CS_LOW_SCLK > CS_HIGH_SCLK) ? CS_LOW_SCLK : CS_HIGH_SCLK;
  localparam int ECNT_W   = $clog2(ECNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ARM, LOW, HIGH} state_t;

  state_t             state;
  logic [DCNT_W-1:0]  dcnt;
  logic [ECNT_W-1:0]  ecnt;
  logic               toggle;
  logic               rise;
  logic               fall;

`ifdef ADC_CONTINUOUS_EN
  logic unused_start;
  assign unused_start = start;
`endif

  assign toggle = (dcnt == DCNT_W'(DIV - 1));
  assign rise   = toggle & ~SCLK;
  assign fall   = toggle & SCLK;

  // SCLK keeps running in every state so the receiver always has a clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt <= '0;
      SCLK <= 1'b1;
    end else if (toggle) begin
      dcnt <= '0;
      SCLK <= ~SCLK;
    end else begin
      dcnt <= dcnt + DCNT_W'(1);
    end
  end

  // CS only moves on rise strobes, keeping it settled around each falling edge the receiver samples on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      CS         <= 1'b1;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      ecnt       <= '0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
`ifdef ADC_CONTINUOUS_EN
          state <= ARM;
          busy  <= 1'b1;
`else
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
`endif
        end
        ARM: begin
          if (rise) begin
            CS    <= 1'b0;
            ecnt  <= '0;
            state <= LOW;
          end
        end
        LOW: begin
          if (fall) begin
            ecnt <= ecnt + ECNT_W'(1);
          end else if (rise && ecnt == ECNT_W'(CS_LOW_SCLK)) begin
            CS         <= 1'b1;
            ecnt       <= '0;
            frame_tick <= 1'b1;
            state      <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            ecnt <= ecnt + ECNT_W'(1);
          end else if (rise && ecnt == ECNT_W'(CS_HIGH_SCLK)) begin
            ecnt <= '0;
`ifdef ADC_CONTINUOUS_EN
            CS    <= 1'b0;
            state <= LOW;
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          CS    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_master.sv
// Self-checking bench for adc_spi_master: compares outputs every clk against a timing model
// derived from edge counts since reset release (honours ADC_CONTINUOUS_EN when defined).
module tb_adc_spi_master;

  localparam int DIV = 2;
  localparam int L   = 17;
  localparam int H   = 3;
  localparam int P2  = 2 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic SCLK, CS, busy, frame_tick;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int ns = 0;
  bit frame_active = 1'b0;

  adc_spi_master #(.DIV(DIV), .CS_LOW_SCLK(L), .CS_HIGH_SCLK(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .SCLK(SCLK), .CS(CS), .busy(busy), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Edge where CS falls for a frame whose start was sampled on edge s.
  function automatic int frame_fall(int s);
    return ((s / P2) + 1) * P2;
  endfunction

  function automatic int frame_end(int s);
    return frame_fall(s) + (L + H) * P2;
  endfunction

  // Expected {SCLK, CS, busy, frame_tick} after edge k counted from reset release.
  function automatic logic [3:0] model(int k);
    logic sclk_e, cs_e, busy_e, tick_e;
    int   rel;
    sclk_e = (((k / DIV) % 2) == 0);
    cs_e   = 1'b1;
    busy_e = 1'b0;
    tick_e = 1'b0;
    rel    = 0;
`ifdef ADC_CONTINUOUS_EN
    busy_e = (k >= 1);
    if (k >= P2) begin
      rel    = (k - P2) % ((L + H) * P2);
      cs_e   = !(rel < L * P2);
      tick_e = (rel == L * P2);
    end
`else
    if (frame_active) begin
      rel    = frame_fall(ns);
      cs_e   = !(k >= rel && k < rel + L * P2);
      busy_e = (k >= ns && k < frame_end(ns));
      tick_e = (k == rel + L * P2);
    end
`endif
    return {sclk_e, cs_e, busy_e, tick_e};
  endfunction

  task automatic tick();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    if (r) begin
      n = 0;
      frame_active = 1'b0;
    end else begin
      n++;
    end
  endtask

  task automatic test_reset();
    int first_fall;
    first_fall = -1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({SCLK, CS, busy, frame_tick} !== 4'b1100) begin
        errors++;
        $display("[TB] FAIL reset_values got=%b expected=1100", {SCLK, CS, busy, frame_tick});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4 * P2; i++) begin
      tick();
      if (!SCLK && first_fall < 0) first_fall = n;
      checks++;
      if ({SCLK, CS, busy, frame_tick} !== model(n)) begin
        errors++;
        $display("[TB] FAIL reset_release n=%0d got=%b expected=%b", n, {SCLK, CS, busy, frame_tick}, model(n));
      end
    end
    checks++;
    if (first_fall != DIV) begin
      errors++;
      $display("[TB] FAIL first_sclk_fall got=%0d expected=%0d", first_fall, DIV);
    end
  endtask

`ifdef ADC_CONTINUOUS_EN
  task automatic test_continuous();
    int last_tick, tick_count;
    last_tick  = -1;
    tick_count = 0;
    for (int i = 0; i < 3 * (L + H) * P2 + P2; i++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({SCLK, CS, busy, frame_tick} !== model(n)) begin
        errors++;
        $display("[TB] FAIL continuous n=%0d got=%b expected=%b", n, {SCLK, CS, busy, frame_tick}, model(n));
      end
      if (frame_tick) begin
        tick_count++;
        if (last_tick >= 0) begin
          checks++;
          if (n - last_tick != (L + H) * P2) begin
            errors++;
            $display("[TB] FAIL tick_period got=%0d expected=%0d", n - last_tick, (L + H) * P2);
          end
        end
        last_tick = n;
      end
    end
    start = 1'b0;
    checks++;
    if (tick_count < 3) begin
      errors++;
      $display("[TB] FAIL continuous_ticks got=%0d expected>=3", tick_count);
    end
  endtask
`else
  task automatic test_single_frame();
    int falls, ticks, stop;
    logic ps;
    falls = 0;
    ticks = 0;
    repeat ($urandom_range(0, 7)) tick();
    ns = n + 1;
    frame_active = 1'b1;
    start = 1'b1;
    stop = frame_end(ns) + 3;
    while (n < stop) begin
      ps = SCLK;
      tick();
      start = 1'b0;
      if (ps && !SCLK && !CS) falls++;
      if (frame_tick) ticks++;
      checks++;
      if ({SCLK, CS, busy, frame_tick} !== model(n)) begin
        errors++;
        $display("[TB] FAIL single_frame n=%0d got=%b expected=%b", n, {SCLK, CS, busy, frame_tick}, model(n));
      end
    end
    checks++;
    if (falls != L) begin
      errors++;
      $display("[TB] FAIL cs_low_falls got=%0d expected=%0d", falls, L);
    end
    checks++;
    if (ticks != 1) begin
      errors++;
      $display("[TB] FAIL frame_tick_count got=%0d expected=1", ticks);
    end
  endtask

  task automatic test_start_ignored();
    int falls, stop;
    logic ps;
    falls = 0;
    repeat ($urandom_range(1, 5)) tick();
    ns = n + 1;
    frame_active = 1'b1;
    start = 1'b1;
    stop = frame_end(ns) + 2 * P2;
    while (n < stop) begin
      ps = SCLK;
      tick();
      // Stray requests only while the frame is still running; afterwards start must be honoured.
      start = (n + 1 <= frame_end(ns)) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ps && !SCLK && !CS) falls++;
      checks++;
      if ({SCLK, CS, busy, frame_tick} !== model(n)) begin
        errors++;
        $display("[TB] FAIL start_ignored n=%0d got=%b expected=%b", n, {SCLK, CS, busy, frame_tick}, model(n));
      end
    end
    start = 1'b0;
    checks++;
    if (falls != L) begin
      errors++;
      $display("[TB] FAIL single_cs_window got=%0d expected=%0d", falls, L);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 2)) tick();
      ns = n + 1;
      frame_active = 1'b1;
      start = 1'b1;
      while (n < frame_end(ns)) begin
        tick();
        start = 1'b0;
        checks++;
        if ({SCLK, CS, busy, frame_tick} !== model(n)) begin
          errors++;
          $display("[TB] FAIL back_to_back f=%0d n=%0d got=%b expected=%b", f, n, {SCLK, CS, busy, frame_tick}, model(n));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int stop;
    repeat ($urandom_range(0, 3)) tick();
    ns = n + 1;
    frame_active = 1'b1;
    start = 1'b1;
    stop = frame_fall(ns) + DIV + 7 * P2;
    while (n < stop) begin
      tick();
      start = 1'b0;
      checks++;
      if ({SCLK, CS, busy, frame_tick} !== model(n)) begin
        errors++;
        $display("[TB] FAIL pre_reset n=%0d got=%b expected=%b", n, {SCLK, CS, busy, frame_tick}, model(n));
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({SCLK, CS, busy, frame_tick} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL mid_frame_reset got=%b expected=1100", {SCLK, CS, busy, frame_tick});
    end
    reset = 1'b0;
    repeat ($urandom_range(0, 5)) tick();
    ns = n + 1;
    frame_active = 1'b1;
    start = 1'b1;
    while (n < frame_end(ns) + 2) begin
      tick();
      start = 1'b0;
      checks++;
      if ({SCLK, CS, busy, frame_tick} !== model(n)) begin
        errors++;
        $display("[TB] FAIL post_reset_frame n=%0d got=%b expected=%b", n, {SCLK, CS, busy, frame_tick}, model(n));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADC_CONTINUOUS_EN
    test_continuous();
`else
    test_single_frame();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_frame();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
